tile_judge_n: RTL
=================

// Module: tile_judge_n
// PURPOSE
//  Parametrised per-window hit judge for the piano-tile game, on div_clk between the tile generator and the score/display logic.
//  Latches LANES-wide tile pattern per window, detects per-lane button presses, reports hits/misses per window.
//  Keeps saturating running total and combo (consecutive perfect windows) counters.
// PARAMETERS
//  LANES          3     number of tile lanes / buttons (1..8)
//  WINDOW_CYCLES  1000  div_clk cycles a window stays open for presses (>=2)
//  TOTAL_W        8     width of running total
//  COMBO_W        6     width of combo counter
//  SW = $clog2(LANES+1) (localparam) width of per-window counts
// PORTS
//  div_clk      in   1        game clock; all state on rising edge
//  rst          in   1        async active-low reset
//  run          in   1        1 = game advancing; 0 = freeze FSM/counter
//  btn_n        in   LANES    raw buttons, active-low, asynchronous; bit LANES-1 = leftmost
//  data         in   LANES    tile pattern from generator, 1 = tile present
//  score        out  SW       hits in last judged window
//  miss         out  SW       unhit tiles in last judged window
//  wrong        out  SW       lanes with wrong press in last window
//  total        out  TOTAL_W  running score, saturating
//  combo        out  COMBO_W  consecutive perfect windows, saturating
//  window_done  out  1        1-cycle pulse when outputs update
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=LOAD, counter 0, tile/hit/wrong regs 0, button sync regs 1 (released).
//  Buttons: 2-flop sync per lane, then press = prev 1 -> cur 0 (falling edge); press visible 3 cycles after pin edge. Holding = one press.
//  FSM: LOAD (1 cycle): tile <= data, hit/wrong <= 0, cnt <= 0 -> OPEN.
//   OPEN: cnt++ each cycle; exits to JUDGE when cnt==WINDOW_CYCLES-1 (exactly WINDOW_CYCLES cycles).
//   JUDGE (1 cycle): update outputs, window_done=1 -> LOAD. Window period WINDOW_CYCLES+2.
//  run=0: FSM, cnt, tile, hit, wrong held; presses ignored; synchronisers keep running. run affects all states.
//  Presses count in OPEN only; presses in LOAD/JUDGE discarded.
//  Per lane in OPEN: press & tile=1 -> hit=1, tile=0 (consumed; later presses on that lane = wrong press).
//   press & tile=0 -> wrong=1 (sticky, max 1 per lane per window). Lanes independent; simultaneous presses all judged.
//  JUDGE: score=popcount(hit); miss=popcount(tile remaining); wrong=popcount(wrong flags).
//   total <= min(total+score, 2^TOTAL_W-1).
//   combo: miss!=0 -> 0; else if score!=0 -> min(combo+1, 2^COMBO_W-1); else (empty window) unchanged.
//  score/miss/wrong/total/combo held between JUDGE cycles; window_done 0 except in JUDGE.
//  Arithmetic: sums at TOTAL_W+1 bits before saturate; no wrap-around anywhere.
//  Reset mid-window: current window discarded, nothing scored; restart at LOAD.
// CONFIGURATION
//  WRONG_PRESS_PENALTY_EN defined: at JUDGE total <= max(sat(total+score)-wrong, 0);
//   wrong!=0 also forces combo <= 0 (overrides increment).
//  Not defined: wrong flags still tracked and wrong output reported; no effect on total or combo.
// TESTING (bench: LANES=3, WINDOW_CYCLES=8, TOTAL_W=4, COMBO_W=3)
//  Reset, data=3'b101, press lanes 2 and 0 in OPEN -> JUDGE: score=2, miss=0, wrong=0, total=2, combo=1, window_done 1 cycle, period 10 cycles.
//  data=3'b010, no press -> score=0, miss=1, combo=0; data=0 window -> combo unchanged, total unchanged.
//  data=3'b100, press lane 2 twice + lane 0 once -> score=1, wrong=2; PENALTY_EN: total +1-2 (clamped at 0), combo=0; else total +1, combo+1.
//  8 perfect windows of data=3'b111 -> total saturates at 15, combo saturates at 7; press held across window -> counted once only.
//  Press during LOAD/JUDGE or with run=0 -> ignored; run=0 for 5 cycles stretches period to 15, window_done suppressed.
//  rst low mid-OPEN after a hit -> all outputs 0 immediately; first window after release judged from fresh LOAD.

Source files
------------

// File: rtl/tile_judge_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tile_judge_n : per-window piano-tile hit judge with saturating total/combo.
// Define WRONG_PRESS_PENALTY_EN to charge wrong presses against total/combo.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tile_judge_n #(
  parameter  int LANES         = 3,
  parameter  int WINDOW_CYCLES = 1000,
  parameter  int TOTAL_W       = 8,
  parameter  int COMBO_W       = 6,
  localparam int SW            = $clog2(LANES + 1)
) (
  input  logic               div_clk,
  input  logic               rst,
  input  logic               run,
  input  logic [LANES-1:0]   btn_n,
  input  logic [LANES-1:0]   data,
  output logic [SW-1:0]      score,
  output logic [SW-1:0]      miss,
  output logic [SW-1:0]      wrong,
  output logic [TOTAL_W-1:0] total,
  output logic [COMBO_W-1:0] combo,
  output logic               window_done
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam int SUM_W = ((TOTAL_W > SW) ? TOTAL_W : SW) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};
  localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_JUDGE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANES-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [LANES-1:0]   tile_q, tile_d, hit_q, hit_d, wrong_flag_q, wrong_flag_d;
  logic [LANES-1:0]   press;
  logic [SW-1:0]      score_q, score_d, miss_q, miss_d, wrong_q, wrong_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               window_done_q, window_done_d;
  logic               load_en, open_en, judge_en;

  logic [SW-1:0]      score_n, miss_n, wrong_n;
  logic [SUM_W-1:0]   tsum;
  logic [TOTAL_W-1:0] tsat, total_n;
  logic [COMBO_W-1:0] combo_inc, combo_n;
  logic               combo_clr;

  function automatic logic [SW-1:0] popcnt(input logic [LANES-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + SW'(v[i]);
    return c;
  endfunction

  // FSM: state register
  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  // FSM: next state; run=0 freezes every state
  always_comb begin
    state_d = state_q;
    if (run) begin
      case (state_q)
        ST_LOAD:  state_d = ST_OPEN;
        ST_OPEN:  if (cnt_q == CNT_LAST) state_d = ST_JUDGE;
        ST_JUDGE: state_d = ST_LOAD;
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    load_en  = 1'b0;
    open_en  = 1'b0;
    judge_en = 1'b0;
    if (run) begin
      case (state_q)
        ST_LOAD: load_en = 1'b1;
        ST_OPEN: begin
          open_en  = 1'b1;
          judge_en = (cnt_q == CNT_LAST);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_press
    assign press[i] = prev_q[i] & ~sync2_q[i];
  end

  always_comb begin
    sync1_d      = btn_n;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    cnt_d        = cnt_q;
    tile_d       = tile_q;
    hit_d        = hit_q;
    wrong_flag_d = wrong_flag_q;
    if (load_en) begin
      tile_d       = data;
      hit_d        = '0;
      wrong_flag_d = '0;
      cnt_d        = '0;
    end else if (open_en) begin
      if (!judge_en) cnt_d = cnt_q + CNT_W'(1);
      // A hit consumes the tile, so a repeat press on that lane is wrong
      for (int i = 0; i < LANES; i++) begin
        if (press[i]) begin
          if (tile_q[i]) begin
            hit_d[i]  = 1'b1;
            tile_d[i] = 1'b0;
          end else begin
            wrong_flag_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // Judged from the _d values so a press on the last open cycle still counts
  always_comb begin
    score_n = popcnt(hit_d);
    miss_n  = popcnt(tile_d);
    wrong_n = popcnt(wrong_flag_d);
    tsum    = SUM_W'(total_q) + SUM_W'(score_n);
    tsat    = (tsum > SUM_W'(TOTAL_MAX)) ? TOTAL_MAX : tsum[TOTAL_W-1:0];
`ifdef WRONG_PRESS_PENALTY_EN
    total_n   = (SUM_W'(wrong_n) >= SUM_W'(tsat)) ? '0 : tsat - TOTAL_W'(wrong_n);
    combo_clr = (miss_n != '0) || (wrong_n != '0);
`else
    total_n   = tsat;
    combo_clr = (miss_n != '0);
`endif
    combo_inc = (combo_q == COMBO_MAX) ? combo_q : combo_q + COMBO_W'(1);
    if (combo_clr)            combo_n = '0;
    else if (score_n != '0)   combo_n = combo_inc;
    else                      combo_n = combo_q;
  end

  always_comb begin
    score_d       = score_q;
    miss_d        = miss_q;
    wrong_d       = wrong_q;
    total_d       = total_q;
    combo_d       = combo_q;
    window_done_d = judge_en;
    if (judge_en) begin
      score_d = score_n;
      miss_d  = miss_n;
      wrong_d = wrong_n;
      total_d = total_n;
      combo_d = combo_n;
    end
  end

  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      prev_q        <= '1;
      cnt_q         <= '0;
      tile_q        <= '0;
      hit_q         <= '0;
      wrong_flag_q  <= '0;
      score_q       <= '0;
      miss_q        <= '0;
      wrong_q       <= '0;
      total_q       <= '0;
      combo_q       <= '0;
      window_done_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      tile_q        <= tile_d;
      hit_q         <= hit_d;
      wrong_flag_q  <= wrong_flag_d;
      score_q       <= score_d;
      miss_q        <= miss_d;
      wrong_q       <= wrong_d;
      total_q       <= total_d;
      combo_q       <= combo_d;
      window_done_q <= window_done_d;
    end
  end

  assign score       = score_q;
  assign miss        = miss_q;
  assign wrong       = wrong_q;
  assign total       = total_q;
  assign combo       = combo_q;
  assign window_done = window_done_q;

endmodule
`default_nettype wire
